text_console: RTL and testbench
===============================

// Module: text_console
// PURPOSE
//  Upstream stage of the GPU text pipeline: consumes a byte stream (CPU/UART) and writes glyph codes into GPU VRAM.
//  Owns an 80x30 cursor; interprets printable ASCII and control codes (CR, LF, BS, FF); auto-wraps lines.
//  Clears the destination row on every row advance, and clears the full screen on FF, by streaming spaces into VRAM.
//  Its vram_* outputs drive the GPU VRAM write port; busy lets the SoC arbitrate CPU writes.
// PARAMETERS
//  VRAM_BASE  16'h2000  bus address of VRAM cell (row 0, col 0)
//  COLS       80        characters per row
//  ROWS       30        rows per screen; COLS*ROWS must be <= 2400
//  FILL_CHAR  8'h20     code written by row/screen clears and BS
// PORTS
//  clk        in   1   system clock; also the GPU VRAM write clock
//  rst        in   1   asynchronous, active-low reset
//  in_data    in   8   byte to print or interpret
//  in_valid   in   1   in_data valid
//  in_ready   out  1   block can accept; transfer occurs on the clk edge where in_valid && in_ready
//  vram_addr  out  16  VRAM write address, VRAM_BASE + row*COLS + col
//  vram_data  out  8   VRAM write data
//  vram_w_en  out  1   one-cycle write strobe
//  cursor_col out  7   current column, 0..COLS-1
//  cursor_row out  5   current row, 0..ROWS-1
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE; col=0, row=0; vram_w_en=0, vram_addr=0, vram_data=0, busy=0.
//   - An in-progress clear is abandoned; it is not resumed.
//  Handshake:
//   - in_ready = (state==IDLE).
//   - Transfer rule: see the in_ready port; in_data is sampled on the transfer edge only.
//  States: IDLE, PUT, CLR_ROW, CLR_ALL. Outputs are registered.
//  IDLE, on transfer, decode in_data:
//   - 0x20..0x7E -> PUT.
//   - 0x0D CR -> col=0; stay IDLE.
//   - 0x0A LF -> col=0; row advance.
//   - 0x08 BS -> if col>0: col-1, then PUT with FILL_CHAR at the new col. At col 0: no-op.
//   - 0x0C FF -> col=0, row=0; CLR_ALL.
//   - All other codes are discarded; stay IDLE.
//  PUT (exactly 1 cycle):
//   - vram_w_en=1, addr per cursor, data=char; return to IDLE.
//   - Printable chars only: col+1. If col was COLS-1: col=0, then row advance.
//   - Throughput is 1 printable char per 2 clk cycles.
//  Row advance:
//   - row = (row==ROWS-1) ? 0 : row+1. The screen wraps; there is no scroll.
//   - Then CLR_ROW.
//  CLR_ROW:
//   - COLS consecutive cycles with vram_w_en=1 and data=FILL_CHAR.
//   - Addresses run from the base of the new row upward by 1; then IDLE.
//  CLR_ALL:
//   - COLS*ROWS cycles, addresses VRAM_BASE .. VRAM_BASE+COLS*ROWS-1; then IDLE.
//  Cursor:
//   - cursor_* report the cursor after any update; they change on the same edge as the update.
//  Arithmetic:
//   - offset = row*COLS + col, 12-bit, always < COLS*ROWS.
//   - vram_addr = VRAM_BASE + zero-extended offset, 16-bit, no overflow.
//   - The fill counter is 12-bit, compared against its terminal value. It never wraps past COLS*ROWS-1.
//  Other rules:
//   - in_valid held high while busy: nothing is accepted, and the data is held by the source.
//   - vram_w_en is never high in IDLE.
// STRUCTURE
//  Shared package gpu_pkg:
//   - COLS, ROWS, VRAM_BASE, FILL_CHAR.
//   - ASCII code constants CR/LF/BS/FF.
//   - The console state enum.
//  Sub-module vram_filler: counter plus address/strobe generator for CLR_ROW/CLR_ALL.
//   - Inputs: start, base offset, length.
//   - Outputs: done, addr, w_en.
//  The cursor/decode FSM stays in text_console.
// TESTING
//  1. Reset, then send 'A' (0x41) -> one cycle with vram_w_en=1, addr 16'h2000, data 0x41; cursor_col=1.
//  2. Cursor (5,3), send LF -> cursor (0,4); 80 writes of 0x20 to 16'h2140..16'h218F; busy high exactly 80 cycles.
//  3. Cursor (79,29), send 'Z' -> write 0x5A @16'h295F; cursor (0,0); 80 clears at 16'h2000..16'h204F.
//  4. Send FF -> 2400 writes 16'h2000..16'h295F of 0x20; cursor (0,0); in_ready low throughout.
//  5. Cursor (0,2), send BS -> no write; then at (4,2) send BS -> write 0x20 @16'h20A3, cursor_col=3.
//  6. Assert rst mid-FF clear -> all outputs 0 immediately; cursor (0,0); in_ready=1 after release.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU text-pipeline constants: screen geometry, VRAM mapping, control codes,
// console state encoding and the cell offset helper.
package gpu_pkg;

  localparam int unsigned COLS  = 80;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned OFF_W = 12;

  localparam logic [15:0] VRAM_BASE = 16'h2000;
  localparam logic [7:0]  FILL_CHAR = 8'h20;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUT     = 2'd1,
    ST_CLR_ROW = 2'd2,
    ST_CLR_ALL = 2'd3
  } console_state_e;

  // Linear cell index; always below CELLS for a legal cursor.
  function automatic logic [OFF_W-1:0] cell_offset(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
    return OFF_W'(row) * OFF_W'(COLS) + OFF_W'(col);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Byte-stream input handshake plus the VRAM write port driven by the console.
interface text_console_if;
  import gpu_pkg::*;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic        vram_w_en;

  // Source side: byte producer, also observes the VRAM port.
  modport master (
    output in_data, in_valid,
    input  in_ready, vram_addr, vram_data, vram_w_en
  );

  // Console side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, vram_addr, vram_data, vram_w_en
  );
endinterface

// File: rtl/vram_filler.sv
// Streams 'len' consecutive VRAM write strobes starting at a cell offset; done marks
// the last strobe so the caller can leave its clear state on the same edge.
module vram_filler
  import gpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OFF_W-1:0] base,
  input  logic [OFF_W-1:0] len,
  output logic             done,
  output logic [15:0]      addr,
  output logic             w_en
);

  logic [OFF_W-1:0] cnt;
  logic [OFF_W-1:0] term;

  // Counter runs 0..len-1 and stops on its terminal value, never wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_en <= 1'b0;
      done <= 1'b0;
      addr <= 16'h0000;
      cnt  <= '0;
      term <= '0;
    end else if (start) begin
      w_en <= 1'b1;
      cnt  <= '0;
      term <= len - OFF_W'(1);
      done <= (len == OFF_W'(1));
      addr <= VRAM_BASE + 16'(base);
    end else if (w_en) begin
      if (done) begin
        w_en <= 1'b0;
        done <= 1'b0;
      end else begin
        cnt  <= cnt + OFF_W'(1);
        addr <= addr + 16'd1;
        done <= ((cnt + OFF_W'(1)) == term);
      end
    end
  end

endmodule

// File: rtl/text_console.sv
// Text console: decodes a byte stream into glyph writes with an 80x30 wrapping cursor,
// clearing the new row on every row advance and the whole screen on form feed.
module text_console
  import gpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  text_console_if.slave    bus,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy
);

  console_state_e   state, state_d;
  logic [COL_W-1:0] col, col_d;
  logic [ROW_W-1:0] row, row_d;
  logic [ROW_W-1:0] row_adv;
  logic             put_we, put_we_d;
  logic [15:0]      put_addr, put_addr_d;
  logic [7:0]       put_data, put_data_d;
  logic             is_print, is_print_d;
  logic             ready_q, busy_q;

  logic             fill_start;
  logic [OFF_W-1:0] fill_base;
  logic [OFF_W-1:0] fill_len;
  logic             fill_done;
  logic [15:0]      fill_addr;
  logic             fill_w_en;

  vram_filler u_filler (
    .clk   (clk),
    .rst   (rst),
    .start (fill_start),
    .base  (fill_base),
    .len   (fill_len),
    .done  (fill_done),
    .addr  (fill_addr),
    .w_en  (fill_w_en)
  );

  // No scroll: the bottom row wraps to the top.
  assign row_adv = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      put_we   <= 1'b0;
      put_addr <= 16'h0000;
      put_data <= 8'h00;
      is_print <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_d;
      col      <= col_d;
      row      <= row_d;
      put_we   <= put_we_d;
      put_addr <= put_addr_d;
      put_data <= put_data_d;
      is_print <= is_print_d;
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  // Decode, cursor update and clear launch.
  always_comb begin
    state_d    = state;
    col_d      = col;
    row_d      = row;
    put_we_d   = 1'b0;
    put_addr_d = put_addr;
    put_data_d = put_data;
    is_print_d = is_print;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_len   = OFF_W'(COLS);

    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            state_d    = ST_PUT;
            put_we_d   = 1'b1;
            put_addr_d = VRAM_BASE + 16'(cell_offset(row, col));
            put_data_d = bus.in_data;
            is_print_d = 1'b1;
          end else begin
            case (bus.in_data)
              CH_CR: col_d = '0;
              CH_LF: begin
                col_d      = '0;
                row_d      = row_adv;
                state_d    = ST_CLR_ROW;
                fill_start = 1'b1;
                fill_base  = cell_offset(row_adv, '0);
              end
              CH_BS: begin
                if (col != '0) begin
                  col_d      = col - COL_W'(1);
                  state_d    = ST_PUT;
                  put_we_d   = 1'b1;
                  put_addr_d = VRAM_BASE + 16'(cell_offset(row, col - COL_W'(1)));
                  put_data_d = FILL_CHAR;
                  is_print_d = 1'b0;
                end
              end
              CH_FF: begin
                col_d      = '0;
                row_d      = '0;
                state_d    = ST_CLR_ALL;
                fill_start = 1'b1;
                fill_base  = '0;
                fill_len   = OFF_W'(CELLS);
              end
              default: ;
            endcase
          end
        end
      end
      ST_PUT: begin
        state_d = ST_IDLE;
        // Backspace already moved the cursor when it was accepted.
        if (is_print) begin
          if (col == COL_W'(COLS - 1)) begin
            col_d      = '0;
            row_d      = row_adv;
            state_d    = ST_CLR_ROW;
            fill_start = 1'b1;
            fill_base  = cell_offset(row_adv, '0);
          end else begin
            col_d = col + COL_W'(1);
          end
        end
      end
      ST_CLR_ROW, ST_CLR_ALL: begin
        if (fill_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single glyph writes and clear streams never overlap, so a simple merge suffices.
  assign bus.vram_w_en = put_we | fill_w_en;
  assign bus.vram_addr = fill_w_en ? fill_addr : put_addr;
  assign bus.vram_data = fill_w_en ? FILL_CHAR : put_data;
  assign bus.in_ready  = ready_q;
  assign busy          = busy_q;
  assign cursor_col    = col;
  assign cursor_row    = row;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: a vector table of single bytes with expected write
// streams and cursor, plus hand sequences for screen wrap and reset during clears.
module tb_text_console;
  import gpu_pkg::*;

  typedef struct {
    logic [7:0]  din;
    int          nwr;
    logic [15:0] first_addr;
    logic [7:0]  first_data;
    logic [15:0] last_addr;
    int          busy_cyc;
    int          col;
    int          row;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;
  int         errors = 0;
  int         checks = 0;
  vec_t       tbl[22];

  text_console_if bus_if ();

  text_console dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one byte for exactly one transfer edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5000; i++) begin
      if (bus_if.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout: in_ready low for 5000 cycles, want 1");
    end
    bus_if.in_data  = b;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
  endtask

  task automatic send_quiet(input logic [7:0] b);
    send_byte(b);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  // Send one byte and record the resulting write stream until the console is idle.
  task automatic run_vec(input string tag, input vec_t v);
    int          nwr, busy_cyc;
    logic [15:0] fa, la, prev;
    logic [7:0]  fd;
    bit          fill_ok, hs_ok, done;
    nwr = 0; busy_cyc = 0; fa = 16'h0; la = 16'h0; prev = 16'h0; fd = 8'h0;
    fill_ok = 1'b1; hs_ok = 1'b1; done = 1'b0;
    send_byte(v.din);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus_if.in_ready == busy) hs_ok = 1'b0;
      if (bus_if.vram_w_en) begin
        if (bus_if.in_ready) hs_ok = 1'b0;
        nwr++;
        if (nwr == 1) begin
          fa = bus_if.vram_addr;
          fd = bus_if.vram_data;
        end else begin
          if (bus_if.vram_data != 8'h20) fill_ok = 1'b0;
          if (nwr > 2 && bus_if.vram_addr != prev + 16'd1) fill_ok = 1'b0;
        end
        prev = bus_if.vram_addr;
        la   = bus_if.vram_addr;
      end
      if (busy) busy_cyc++;
      else begin done = 1'b1; break; end
    end
    check({tag, " idle_reached"}, int'(done), 1);
    check({tag, " writes"}, nwr, v.nwr);
    check({tag, " busy_cycles"}, busy_cyc, v.busy_cyc);
    check({tag, " col"}, int'(cursor_col), v.col);
    check({tag, " row"}, int'(cursor_row), v.row);
    check({tag, " handshake"}, int'(hs_ok), 1);
    if (v.nwr > 0) begin
      check({tag, " first_addr"}, int'(fa), int'(v.first_addr));
      check({tag, " first_data"}, int'(fd), int'(v.first_data));
      check({tag, " last_addr"}, int'(la), int'(v.last_addr));
      check({tag, " fill_stream"}, int'(fill_ok), 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " w_en"}, int'(bus_if.vram_w_en), 0);
    check({tag, " addr"}, int'(bus_if.vram_addr), 0);
    check({tag, " data"}, int'(bus_if.vram_data), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " col"}, int'(cursor_col), 0);
    check({tag, " row"}, int'(cursor_row), 0);
  endtask

  initial begin
    vec_t zv;
    // din, nwr, first_addr, first_data, last_addr, busy, col, row
    tbl[0]  = '{8'h41, 1,    16'h2000, 8'h41, 16'h2000, 1,    1, 0};
    tbl[1]  = '{8'h0D, 0,    16'h0000, 8'h00, 16'h0000, 0,    0, 0};
    tbl[2]  = '{8'h0A, 80,   16'h2050, 8'h20, 16'h209F, 80,   0, 1};
    tbl[3]  = '{8'h0A, 80,   16'h20A0, 8'h20, 16'h20EF, 80,   0, 2};
    tbl[4]  = '{8'h08, 0,    16'h0000, 8'h00, 16'h0000, 0,    0, 2};
    tbl[5]  = '{8'h61, 1,    16'h20A0, 8'h61, 16'h20A0, 1,    1, 2};
    tbl[6]  = '{8'h62, 1,    16'h20A1, 8'h62, 16'h20A1, 1,    2, 2};
    tbl[7]  = '{8'h01, 0,    16'h0000, 8'h00, 16'h0000, 0,    2, 2};
    tbl[8]  = '{8'h63, 1,    16'h20A2, 8'h63, 16'h20A2, 1,    3, 2};
    tbl[9]  = '{8'h64, 1,    16'h20A3, 8'h64, 16'h20A3, 1,    4, 2};
    tbl[10] = '{8'h08, 1,    16'h20A3, 8'h20, 16'h20A3, 1,    3, 2};
    tbl[11] = '{8'h7F, 0,    16'h0000, 8'h00, 16'h0000, 0,    3, 2};
    tbl[12] = '{8'h0A, 80,   16'h20F0, 8'h20, 16'h213F, 80,   0, 3};
    tbl[13] = '{8'h31, 1,    16'h20F0, 8'h31, 16'h20F0, 1,    1, 3};
    tbl[14] = '{8'h32, 1,    16'h20F1, 8'h32, 16'h20F1, 1,    2, 3};
    tbl[15] = '{8'h33, 1,    16'h20F2, 8'h33, 16'h20F2, 1,    3, 3};
    tbl[16] = '{8'h34, 1,    16'h20F3, 8'h34, 16'h20F3, 1,    4, 3};
    tbl[17] = '{8'h35, 1,    16'h20F4, 8'h35, 16'h20F4, 1,    5, 3};
    tbl[18] = '{8'h0A, 80,   16'h2140, 8'h20, 16'h218F, 80,   0, 4};
    tbl[19] = '{8'h0C, 2400, 16'h2000, 8'h20, 16'h295F, 2400, 0, 0};
    tbl[20] = '{8'h7E, 1,    16'h2000, 8'h7E, 16'h2000, 1,    1, 0};
    tbl[21] = '{8'h20, 1,    16'h2001, 8'h20, 16'h2001, 1,    2, 0};

    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset in_ready", int'(bus_if.in_ready), 1);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Walk the cursor to the last cell, then print into it to force a screen wrap.
    send_quiet(8'h0C);
    for (int i = 0; i < 29; i++) send_quiet(8'h0A);
    for (int i = 0; i < 79; i++) send_quiet(8'h78);
    check("corner col", int'(cursor_col), 79);
    check("corner row", int'(cursor_row), 29);
    zv = '{8'h5A, 81, 16'h295F, 8'h5A, 16'h204F, 81, 0, 0};
    run_vec("wrap", zv);

    // Reset in the middle of a row clear; the clear must not resume afterwards.
    send_byte(8'h0A);
    repeat (20) @(negedge clk);
    check("mid_lf w_en", int'(bus_if.vram_w_en), 1);
    check("mid_lf row", int'(cursor_row), 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_lf");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_lf in_ready", int'(bus_if.in_ready), 1);
    check("rst_lf w_en_after", int'(bus_if.vram_w_en), 0);
    zv = '{8'h42, 1, 16'h2000, 8'h42, 16'h2000, 1, 1, 0};
    run_vec("after_rst_lf", zv);

    // Reset in the middle of a full-screen clear.
    send_byte(8'h0C);
    repeat (1000) @(negedge clk);
    check("mid_ff w_en", int'(bus_if.vram_w_en), 1);
    check("mid_ff in_ready", int'(bus_if.in_ready), 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("rst_ff");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ff in_ready", int'(bus_if.in_ready), 1);
    zv = '{8'h0D, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0};
    run_vec("after_rst_ff", zv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
